// File: rtl/d16_encode_pkg.sv
// Shared d16 definitions: opcodes, operand formats, error codes and encoder states.
// Range checking in the encoder is compiled in with D16_ENCODE_RANGE_CHECK_EN.
package d16_encode_pkg;

  localparam logic [7:0] D16_OP_ADD = 8'h01;
  localparam logic [7:0] D16_OP_SUB = 8'h02;
  localparam logic [7:0] D16_OP_SHL = 8'h03;
  localparam logic [7:0] D16_OP_SHR = 8'h04;
  localparam logic [7:0] D16_OP_OR  = 8'h05;
  localparam logic [7:0] D16_OP_AND = 8'h06;
  localparam logic [7:0] D16_OP_EQU = 8'h07;
  localparam logic [7:0] D16_OP_LTE = 8'h08;
  localparam logic [7:0] D16_OP_GTE = 8'h09;
  localparam logic [7:0] D16_OP_LT  = 8'h0A;
  localparam logic [7:0] D16_OP_GT  = 8'h0B;
  localparam logic [7:0] D16_OP_STP = 8'h0C;
  localparam logic [7:0] D16_OP_LOP = 8'h0D;
  localparam logic [7:0] D16_OP_COP = 8'h0E;
  localparam logic [7:0] D16_OP_AFC = 8'h0F;
  localparam logic [7:0] D16_OP_LOD = 8'h10;
  localparam logic [7:0] D16_OP_STR = 8'h11;
  localparam logic [7:0] D16_OP_JMZ = 8'h12;
  localparam logic [7:0] D16_OP_JMP = 8'h13;

  // Word layouts: RRR {a,b,c}, RR {a,b,0}, RIMM {a,b16}, AR {a16,b}, A {a16,0}.
  typedef enum logic [2:0] {
    D16_FMT_RRR,
    D16_FMT_RR,
    D16_FMT_RIMM,
    D16_FMT_AR,
    D16_FMT_A,
    D16_FMT_NONE
  } d16_fmt_e;

  localparam logic [1:0] D16_ERR_NONE  = 2'd0;
  localparam logic [1:0] D16_ERR_OP    = 2'd1;
  localparam logic [1:0] D16_ERR_RANGE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } d16_enc_state_e;

  function automatic d16_fmt_e d16_op_fmt(input logic [7:0] op);
    case (op)
      D16_OP_ADD, D16_OP_SUB, D16_OP_SHL, D16_OP_SHR, D16_OP_OR,
      D16_OP_AND, D16_OP_EQU, D16_OP_LTE, D16_OP_GTE, D16_OP_LT,
      D16_OP_GT, D16_OP_STP, D16_OP_LOP: return D16_FMT_RRR;
      D16_OP_COP:                        return D16_FMT_RR;
      D16_OP_AFC, D16_OP_LOD:            return D16_FMT_RIMM;
      D16_OP_STR, D16_OP_JMZ:            return D16_FMT_AR;
      D16_OP_JMP:                        return D16_FMT_A;
      default:                           return D16_FMT_NONE;
    endcase
  endfunction

  // A byte the decoder zero-extends must have an empty high byte.
  function automatic logic d16_zx_ok(input logic [15:0] v);
    return v[15:8] == 8'h00;
  endfunction

  // A byte the decoder sign-extends must have its high byte copy bit 7.
  function automatic logic d16_sx_ok(input logic [15:0] v);
    return v[15:8] == {8{v[7]}};
  endfunction

endpackage

// File: rtl/d16_encode_pack.sv
// Combinational packer: decoded (op, a, b, c) to a 32-bit d16 word plus legality flags.
// Operand range rules are evaluated only when D16_ENCODE_RANGE_CHECK_EN is defined.
module d16_encode_pack
  import d16_encode_pkg::*;
(
  input  logic [7:0]  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [15:0] c_i,
  output logic [31:0] instr_o,
  output logic        fmt_ok_o,
  output logic        range_ok_o
);

  d16_fmt_e fmt;

  assign fmt = d16_op_fmt(op_i);

  always_comb begin
    instr_o  = {op_i, 24'h000000};
    fmt_ok_o = 1'b1;
    case (fmt)
      D16_FMT_RRR:  instr_o = {op_i, a_i[7:0], b_i[7:0], c_i[7:0]};
      D16_FMT_RR:   instr_o = {op_i, a_i[7:0], b_i[7:0], 8'h00};
      D16_FMT_RIMM: instr_o = {op_i, a_i[7:0], b_i[15:8], b_i[7:0]};
      D16_FMT_AR:   instr_o = {op_i, a_i[15:8], a_i[7:0], b_i[7:0]};
      D16_FMT_A:    instr_o = {op_i, a_i[15:8], a_i[7:0], 8'h00};
      default:      fmt_ok_o = 1'b0;
    endcase
  end

`ifdef D16_ENCODE_RANGE_CHECK_EN
  // Fields packed as constant zero are never checked.
  always_comb begin
    range_ok_o = 1'b1;
    case (fmt)
      D16_FMT_RRR: range_ok_o =
          ((op_i == D16_OP_STP) ? d16_sx_ok(a_i) : d16_zx_ok(a_i)) &&
          ((op_i == D16_OP_LOP) ? d16_sx_ok(b_i) : d16_zx_ok(b_i)) &&
          d16_zx_ok(c_i);
      D16_FMT_RR:   range_ok_o = d16_zx_ok(a_i) && d16_zx_ok(b_i);
      D16_FMT_RIMM: range_ok_o = d16_zx_ok(a_i);
      D16_FMT_AR:   range_ok_o = d16_zx_ok(b_i);
      default:      range_ok_o = 1'b1;
    endcase
  end
`else
  assign range_ok_o = 1'b1;
`endif

endmodule

// File: rtl/d16_encode.sv
// Streaming d16 instruction encoder/loader: packs tuples and writes them to memory.
// Build with D16_ENCODE_RANGE_CHECK_EN to reject out-of-range operand fields.
module d16_encode
  import d16_encode_pkg::*;
#(
  parameter int ADR_W = 10,
  parameter int LEN_W = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_op,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [15:0]      in_c,
  output logic             mem_we,
  output logic [ADR_W-1:0] mem_adr,
  output logic [31:0]      mem_dat,
  input  logic             mem_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [LEN_W-1:0] err_index,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer occurs on a rising edge where valid && ready; the
  // sender holds payload stable while valid && !ready.

  d16_enc_state_e   state_q;
  logic [ADR_W-1:0] base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             mem_we_q;
  logic [ADR_W-1:0] mem_adr_q;
  logic [31:0]      mem_dat_q;
  logic             done_q;
  logic [1:0]       err_code_q;
  logic [LEN_W-1:0] err_index_q;

  logic [31:0] instr;
  logic        fmt_ok;
  logic        range_ok;
  logic        accept;
  logic        last_tuple;

  d16_encode_pack u_pack (
    .op_i       (in_op),
    .a_i        (in_a),
    .b_i        (in_b),
    .c_i        (in_c),
    .instr_o    (instr),
    .fmt_ok_o   (fmt_ok),
    .range_ok_o (range_ok)
  );

  assign in_ready   = (state_q == ST_RUN) && (!mem_we_q || mem_ready);
  assign accept     = in_valid && in_ready;
  assign last_tuple = (cnt_q == (len_q - LEN_W'(1)));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_dat_q   <= '0;
      done_q      <= 1'b0;
      err_code_q  <= D16_ERR_NONE;
      err_index_q <= '0;
    end else begin
      done_q <= 1'b0;
      // The write register drains in every state, including ERR.
      if (mem_we_q && mem_ready) mem_we_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            base_q      <= base_adr;
            len_q       <= len;
            cnt_q       <= '0;
            err_code_q  <= D16_ERR_NONE;
            err_index_q <= '0;
            if (len == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (!fmt_ok) begin
              state_q     <= ST_ERR;
              err_code_q  <= D16_ERR_OP;
              err_index_q <= cnt_q;
            end else if (!range_ok) begin
              state_q     <= ST_ERR;
              err_code_q  <= D16_ERR_RANGE;
              err_index_q <= cnt_q;
            end else begin
              mem_we_q  <= 1'b1;
              mem_adr_q <= base_q + ADR_W'(cnt_q);
              mem_dat_q <= instr;
              cnt_q     <= cnt_q + LEN_W'(1);
              if (last_tuple) state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Empty now, or emptying on this edge.
          if (!mem_we_q || mem_ready) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_dat   = mem_dat_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = done_q;
  assign err       = (state_q == ST_ERR);
  assign err_code  = err_code_q;
  assign err_index = err_index_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_d16_encode.sv
// Self-checking bench for d16_encode: packing table, multi-cycle corner sequences.
// Expectations follow D16_ENCODE_RANGE_CHECK_EN when it is defined for the build.
module tb_d16_encode;
  import d16_encode_pkg::*;

  localparam int ADR_W = 10;
  localparam int LEN_W = 10;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             start = 1'b0;
  logic [ADR_W-1:0] base_adr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_op = '0;
  logic [15:0]      in_a = '0;
  logic [15:0]      in_b = '0;
  logic [15:0]      in_c = '0;
  logic             mem_we;
  logic [ADR_W-1:0] mem_adr;
  logic [31:0]      mem_dat;
  logic             mem_ready = 1'b1;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [LEN_W-1:0] err_index;
  logic [2:0]       dbg_state;

  d16_encode #(.ADR_W(ADR_W), .LEN_W(LEN_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .base_adr  (base_adr),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_dat   (mem_dat),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .err_index (err_index),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  int prev_wr_cyc = 0;
  logic [ADR_W+31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sampled on the falling edge; inputs only change just after the rising edge.
  always @(negedge sys_clk) begin
    if (!sys_rst && mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got adr %h dat %h expected no write", mem_adr, mem_dat);
      end else begin
        logic [ADR_W+31:0] e;
        e = exp_q.pop_front();
        check("wr_adr", 64'(mem_adr), 64'(e[ADR_W+31:32]));
        check("wr_dat", 64'(mem_dat), 64'(e[31:0]));
      end
      wr_cnt++;
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
    end
    if (!sys_rst && done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_start(input logic [ADR_W-1:0] b, input logic [LEN_W-1:0] l);
    start = 1'b1;
    base_adr = b;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input bit push,
                      input logic [ADR_W-1:0] e_adr, input logic [31:0] e_dat);
    int n;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_c = c;
    if (push) exp_q.push_back({e_adr, e_dat});
    n = 0;
    forever begin
      @(negedge sys_clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        check("send_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done_cnt > d0) begin
        seen = 1;
        break;
      end
    end
    check(name, 64'(seen), 64'd1);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [31:0] dat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{D16_OP_ADD, 16'h0001, 16'h0002, 16'h0003, 32'h01010203};
    vecs[1]  = '{D16_OP_SUB, 16'h00FF, 16'h0000, 16'h0080, 32'h02FF0080};
    vecs[2]  = '{D16_OP_GT,  16'h0011, 16'h0022, 16'h0033, 32'h0B112233};
    vecs[3]  = '{D16_OP_STP, 16'hFF90, 16'h0001, 16'h0002, 32'h0C900102};
    vecs[4]  = '{D16_OP_LOP, 16'h0005, 16'hFF80, 16'h0007, 32'h0D058007};
    vecs[5]  = '{D16_OP_COP, 16'h0003, 16'h0004, 16'hFFFF, 32'h0E030400};
    vecs[6]  = '{D16_OP_AFC, 16'h0004, 16'h1234, 16'h0000, 32'h0F041234};
    vecs[7]  = '{D16_OP_LOD, 16'h0007, 16'hBEEF, 16'h5555, 32'h1007BEEF};
    vecs[8]  = '{D16_OP_STR, 16'h1234, 16'h0056, 16'h9999, 32'h11123456};
    vecs[9]  = '{D16_OP_JMZ, 16'h0F0F, 16'h00AA, 16'h0000, 32'h120F0FAA};
    vecs[10] = '{D16_OP_JMP, 16'hABCD, 16'h7777, 16'h8888, 32'h13ABCD00};
    vecs[11] = '{D16_OP_SHR, 16'h007F, 16'h0000, 16'h00FF, 32'h047F00FF};

    // reset
    repeat (3) tick();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_err_index", 64'(err_index), 64'd0);
    check("rst_mem_adr", 64'(mem_adr), 64'd0);
    check("rst_mem_dat", 64'(mem_dat), 64'd0);
    tick();

    // zero-length job completes at once
    do_start(10'd9, 10'd0);
    wait_done("len0_done");
    check("len0_busy", 64'(busy), 64'd0);

    // packing table as one job
    do_start(10'd0, LEN_W'(NV));
    check("run_busy", 64'(busy), 64'd1);
    for (int i = 0; i < NV; i++)
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, 1'b1, ADR_W'(i), vecs[i].dat);
    wait_done("table_done");
    check("table_writes", 64'(wr_cnt), 64'(NV + 0));
    check("table_busy_after", 64'(busy), 64'd0);

    // AFC then JMP back to back from base 5
    do_start(10'd5, 10'd2);
    send(D16_OP_AFC, 16'h0004, 16'h1234, 16'h0000, 1'b1, 10'd5, 32'h0F041234);
    send(D16_OP_JMP, 16'hABCD, 16'h0000, 16'h0000, 1'b1, 10'd6, 32'h13ABCD00);
    wait_done("b2b_done");
    check("b2b_gap", 64'(last_wr_cyc - prev_wr_cyc), 64'd1);

    // sign-extended LOP accepted, then ADD with b out of range
    do_start(10'd20, 10'd2);
    send(D16_OP_LOP, 16'h0000, 16'hFF80, 16'h0000, 1'b1, 10'd20, 32'h0D008000);
`ifdef D16_ENCODE_RANGE_CHECK_EN
    begin
      int d0;
      d0 = done_cnt;
      send(D16_OP_ADD, 16'h0001, 16'h0100, 16'h0002, 1'b0, 10'd0, 32'h0);
      repeat (3) tick();
      check("range_err", 64'(err), 64'd1);
      check("range_err_code", 64'(err_code), 64'd2);
      check("range_err_index", 64'(err_index), 64'd1);
      check("range_busy", 64'(busy), 64'd0);
      check("range_in_ready", 64'(in_ready), 64'd0);
      check("range_no_done", 64'(done_cnt - d0), 64'd0);
      check("range_sb_empty", 64'(exp_q.size()), 64'd0);
    end
`else
    send(D16_OP_ADD, 16'h0001, 16'h0100, 16'h0002, 1'b1, 10'd21, 32'h01010002);
    wait_done("trunc_done");
    check("trunc_err", 64'(err), 64'd0);
`endif

    // unknown opcode at index 3 of a 6-tuple job, then clear with start
    do_start(10'd100, 10'd6);
    for (int i = 0; i < 3; i++)
      send(D16_OP_ADD, 16'(i), 16'h0010, 16'h0020, 1'b1, ADR_W'(100 + i),
           {8'h01, 8'(i), 8'h10, 8'h20});
    send(8'hFE, 16'h0000, 16'h0000, 16'h0000, 1'b0, 10'd0, 32'h0);
    repeat (3) tick();
    check("op_err", 64'(err), 64'd1);
    check("op_err_code", 64'(err_code), 64'd1);
    check("op_err_index", 64'(err_index), 64'd3);
    check("op_sb_empty", 64'(exp_q.size()), 64'd0);
    do_start(10'd0, 10'd0);
    wait_done("clear_done");
    check("clear_err", 64'(err), 64'd0);
    check("clear_err_code", 64'(err_code), 64'd0);

    // address wrap with a 4-cycle memory stall
    do_start(10'd1023, 10'd3);
    send(D16_OP_ADD, 16'h000A, 16'h000B, 16'h000C, 1'b1, 10'd1023, 32'h010A0B0C);
    mem_ready = 1'b0;
    in_valid = 1'b1;
    in_op = D16_OP_ADD;
    in_a = 16'h0001;
    in_b = 16'h0001;
    in_c = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_mem_we", 64'(mem_we), 64'd1);
      check("stall_mem_adr", 64'(mem_adr), 64'd1023);
      check("stall_mem_dat", 64'(mem_dat), 64'h010A0B0C);
      tick();
    end
    mem_ready = 1'b1;
    send(D16_OP_ADD, 16'h0001, 16'h0001, 16'h0001, 1'b1, 10'd0, 32'h01010101);
    send(D16_OP_ADD, 16'h0002, 16'h0002, 16'h0002, 1'b1, 10'd1, 32'h01020202);
    wait_done("wrap_done");

    // reset while draining with a write pending
    begin
      int d0;
      int w0;
      do_start(10'd7, 10'd1);
      mem_ready = 1'b0;
      send(D16_OP_ADD, 16'h0001, 16'h0001, 16'h0001, 1'b1, 10'd7, 32'h01010101);
      @(negedge sys_clk);
      check("drain_busy", 64'(busy), 64'd1);
      check("drain_mem_we", 64'(mem_we), 64'd1);
      tick();
      d0 = done_cnt;
      w0 = wr_cnt;
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      exp_q.delete();
      mem_ready = 1'b1;
      @(negedge sys_clk);
      check("mrst_mem_we", 64'(mem_we), 64'd0);
      check("mrst_busy", 64'(busy), 64'd0);
      check("mrst_done", 64'(done), 64'd0);
      check("mrst_err", 64'(err), 64'd0);
      check("mrst_in_ready", 64'(in_ready), 64'd0);
      check("mrst_mem_adr", 64'(mem_adr), 64'd0);
      check("mrst_mem_dat", 64'(mem_dat), 64'd0);
      repeat (5) tick();
      check("mrst_no_done", 64'(done_cnt - d0), 64'd0);
      check("mrst_no_write", 64'(wr_cnt - w0), 64'd0);
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
